alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one alu_4bit datapath between NUM_REQ requesters using round-robin arbitration.
//   - Request side: per-requester valid/ready handshake.
//   - Response side: single registered result with the requester ID attached.
//   - Sits between the requester front-ends and the ALU instance.
//   - Owns sequencing of operands into the ALU and capture of its result.
// PARAMETERS
//   NUM_REQ  4  number of requesters sharing the ALU (2..8)
//   ID_W     2  requester-ID width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   clk         in   1          rising-edge clock; the block has one clock
//   rst_n       in   1          asynchronous, active-low reset
//   req_valid   in   NUM_REQ    per-requester request valid
//   req_ready   out  NUM_REQ    per-requester accept; one-hot or zero
//   req_a       in   4*NUM_REQ  operand A, requester i at [4i+3:4i]
//   req_b       in   4*NUM_REQ  operand B, same packing as req_a
//   req_sel     in   2*NUM_REQ  op select, requester i at [2i+1:2i]: 00 add, 01 sub, 10 and, 11 or
//   rsp_valid   out  1          response valid
//   rsp_ready   in   1          response consumer ready
//   rsp_result  out  4          ALU result
//   rsp_carry   out  1          add: carry-out; sub: bit 4 of 5-bit a-b (borrow); and/or: 0
//   rsp_id      out  ID_W       index of the requester this response belongs to
//   busy        out  1          high whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset: FSM=IDLE; rr_ptr=0; rsp_valid, rsp_result, rsp_carry, rsp_id, busy all 0; req_ready=0.
//   FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE
//     - If any req_valid: grant the first set bit searching from rr_ptr upward, wrapping mod NUM_REQ.
//     - req_ready[grant] is combinational, asserted in IDLE only, in the same cycle.
//     - On that edge: latch a, b, sel and grant index; go to EXEC.
//     - If no req_valid: stay in IDLE.
//   EXEC
//     - Latched operands drive the ALU.
//     - On the edge: capture {carry, result} and the ID into response registers; go to RESP.
//   RESP
//     - rsp_valid=1; rsp_* held stable until the cycle with rsp_ready=1.
//     - On that edge: rsp_valid->0, rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
//   Latency: accept at edge N -> rsp_valid high from cycle N+2.
//     - Minimum 3 cycles per operation when rsp_ready is held high.
//   Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
//   Requesters hold req_valid and operands stable until ready; the block does not check this.
//     - Deasserting req_valid before grant simply removes the request.
//   req_ready is never asserted in EXEC or RESP (no overlap, no buffering beyond one op).
//   Simultaneous: new requests arriving while in RESP wait; pointer update precedes the next grant.
//   Arithmetic:
//     - add: {carry, result} = a + b, 5-bit.
//     - sub: {carry, result} = {1'b0,a} - {1'b0,b}, 5-bit wrap.
//   Reset mid-operation: asynchronous clear of all state.
//     - Any in-flight operation is dropped and no response is issued.
//     - rr_ptr returns to 0.
//   Unused ID codes (rr_ptr >= NUM_REQ) are unreachable; the FSM default branch returns to IDLE.
// STRUCTURE
//   Shared header alu_defs.vh:
//     - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
//     - FSM state encodings S_IDLE, S_EXEC, S_RESP.
//   Sub-modules:
//     - One existing alu_4bit instance as the datapath.
//     - One new sub-module rr_arbiter (NUM_REQ requests, rotating pointer, one-hot grant + index).
//     - The FSM and response registers stay in this module.
// TESTING
//   1. Reset with all inputs 0 -> all outputs 0; busy=0; no req_ready for 10 cycles.
//   2. req0 add a=9 b=8 -> req_ready[0] same cycle; 2 cycles later rsp_result=1, rsp_carry=1, rsp_id=0.
//   3. req2 sub a=3 b=5 -> rsp_result=4'hE, rsp_carry=1, rsp_id=2; then and 4'hC,4'hA -> result 8, carry 0.
//   4. All 4 requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response every 3 cycles.
//   5. rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, busy=1, req_ready=0; release -> grant resumes.
//   6. Assert rst_n=0 while in EXEC -> rsp_valid never rises; after release with req3,req0 valid -> grant req0.

Source files
------------

// File: rtl/alu_rr_scheduler_pkg.sv
// ============================================================================
//  Module   : alu_rr_scheduler_pkg
//  Purpose  : Opcode constants and FSM state type shared by the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_rr_scheduler_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_rr_scheduler_if.sv
// ============================================================================
//  Module   : alu_rr_scheduler_if
//  Purpose  : Request/response bus between requester front-ends and scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0] req_sel;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [3:0]           rsp_result;
    logic                 rsp_carry;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id
    );
endinterface

`default_nettype wire

// File: rtl/alu_4bit.sv
// ============================================================================
//  Module   : alu_4bit
//  Purpose  : 4-bit add/sub/and/or datapath with a 5th carry/borrow bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_4bit
    import alu_rr_scheduler_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] result,
    output logic       carry
);

    logic [4:0] w_wide;

    always_comb begin
        w_wide = 5'd0;
        case (sel)
            OP_ADD:  w_wide = {1'b0, a} + {1'b0, b};
            // Bit 4 of the wrapped difference is the borrow.
            OP_SUB:  w_wide = {1'b0, a} - {1'b0, b};
            OP_AND:  w_wide = {1'b0, a & b};
            OP_OR:   w_wide = {1'b0, a | b};
            default: w_wide = 5'd0;
        endcase
    end

    assign result = w_wide[3:0];
    assign carry  = w_wide[4];

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick starting at a rotating pointer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk the search order backwards so the earliest candidate overwrites last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                grant_any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
// ============================================================================
//  Module   : alu_rr_scheduler
//  Purpose  : Shares one alu_4bit between NUM_REQ requesters, round-robin.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_scheduler_if.slave bus,
    output logic              busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_grant_any;
    logic [3:0]           r_a;
    logic [3:0]           r_b;
    logic [1:0]           r_sel;
    logic [ID_W-1:0]      r_id;
    logic                 r_rsp_valid;
    logic [3:0]           r_rsp_result;
    logic                 r_rsp_carry;
    logic [ID_W-1:0]      r_rsp_id;
    logic [3:0]           w_alu_result;
    logic                 w_alu_carry;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [3:0]           w_a_arr   [NUM_REQ];
    logic [3:0]           w_b_arr   [NUM_REQ];
    logic [1:0]           w_sel_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_a_arr[gi]   = bus.req_a[4*gi +: 4];
        assign w_b_arr[gi]   = bus.req_b[4*gi +: 4];
        assign w_sel_arr[gi] = bus.req_sel[2*gi +: 2];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    alu_4bit u_alu (
        .a      (r_a),
        .b      (r_b),
        .sel    (r_sel),
        .result (w_alu_result),
        .carry  (w_alu_carry)
    );

    assign w_ptr_nxt = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // req_ready is only ever offered while idle, so at most one op is in flight.
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    bus.req_ready = w_grant;
                    w_state_nxt   = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= '0;
            r_id         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_id     <= '0;
        end else begin
            if (r_state == S_IDLE && w_grant_any) begin
                r_a   <= w_a_arr[w_grant_idx];
                r_b   <= w_b_arr[w_grant_idx];
                r_sel <= w_sel_arr[w_grant_idx];
                r_id  <= w_grant_idx;
            end
            if (r_state == S_EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_alu_result;
                r_rsp_carry  <= w_alu_carry;
                r_rsp_id     <= r_id;
            end
            if (r_state == S_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_ptr       <= w_ptr_nxt;
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_id     = r_rsp_id;
    assign busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire
